// File: rtl/interrupt_controller_pkg.sv
// Shared pipeline definitions for the interrupt controller: FSM state
// encodings, the default handler entry address and the take qualifier.
package interrupt_controller_pkg;

  // Handler entry address used when the instantiating pipeline does not override it.
  localparam logic [31:0] VECTOR_DEFAULT = 32'h0000_0100;

  // Controller states: waiting, one-cycle vector entry, handler running.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VECTOR  = 2'd1,
    ST_HANDLER = 2'd2
  } irq_state_e;

  // An interrupt may only be taken on a real, non-mret instruction in Execute
  // while interrupts are globally enabled, so that epc captures a valid PC.
  function automatic logic take_qualified(input logic irq_sync,
                                          input logic global_ie,
                                          input logic valid_e,
                                          input logic mret_e);
    return irq_sync & global_ie & valid_e & ~mret_e;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs. A rising input that
// arrives before edge N is visible on q after edge N+1.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops to resolve metastability; cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/interrupt_controller.sv
// Single-level, non-nesting interrupt controller for the pipeline.
// Takes an interrupt on a qualified Execute instruction (killing D/E/M),
// redirects to VECTOR for one cycle, runs the handler and returns to epc
// on mret. Redirect outputs are combinational so the kill lands in the
// same cycle as the decision.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [31:0] VECTOR = VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        global_ie,
  input  logic [31:0] PCE,
  input  logic        validE,
  input  logic        mretE,
  output logic        stopped_interrupt,
  output logic        interrupt_en,
  output logic        PCIntSel,
  output logic [31:0] PCInt,
  output logic        irq_ack,
  output logic        in_handler,
  output logic [31:0] epc
);

  irq_state_e  state_q;
  irq_state_e  state_d;
  logic [31:0] epc_q;
  logic [31:0] epc_d;
  logic        irq_s;
  logic        take_s;
  logic        ret_s;

  sync_2ff #(
    .WIDTH (1)
  ) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irq),
    .q     (irq_s)
  );

  assign take_s = (state_q == ST_IDLE) && take_qualified(irq_s, global_ie, validE, mretE);
  assign ret_s  = (state_q == ST_HANDLER) && mretE && validE;

  // Next-state, epc capture and output decode; everything defaults to idle/zero.
  always_comb begin
    state_d           = state_q;
    epc_d             = epc_q;
    stopped_interrupt = 1'b0;
    interrupt_en      = 1'b0;
    PCIntSel          = 1'b0;
    PCInt             = 32'h0000_0000;
    irq_ack           = 1'b0;
    in_handler        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          stopped_interrupt = 1'b1;
          epc_d             = PCE;
          state_d           = ST_VECTOR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VECTOR: begin
        interrupt_en = 1'b1;
        PCIntSel     = 1'b1;
        PCInt        = VECTOR;
        irq_ack      = 1'b1;
        state_d      = ST_HANDLER;
      end
      ST_HANDLER: begin
        in_handler = 1'b1;
        if (ret_s) begin
          stopped_interrupt = 1'b1;
          PCIntSel          = 1'b1;
          PCInt             = epc_q;
          state_d           = ST_IDLE;
        end else begin
          state_d = ST_HANDLER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any handler without a return redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Saved return PC; only changes on a take.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc_q <= 32'h0000_0000;
    end else begin
      epc_q <= epc_d;
    end
  end

  assign epc = epc_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller. The stimulus process pushes the
// expected output snapshot for every cycle in which the controller should
// show a redirect/ack event; a monitor pops and compares on every cycle the
// DUT actually shows one, and flags events nobody expected.
module tb_interrupt_controller;

  typedef struct packed {
    logic        stop;
    logic        ien;
    logic        sel;
    logic        ack;
    logic        inh;
    logic [31:0] pcint;
    logic [31:0] epc;
  } obs_t;

  logic        clk;
  logic        reset;
  logic        irq;
  logic        global_ie;
  logic [31:0] PCE;
  logic        validE;
  logic        mretE;
  logic        stopped_interrupt;
  logic        interrupt_en;
  logic        PCIntSel;
  logic [31:0] PCInt;
  logic        irq_ack;
  logic        in_handler;
  logic [31:0] epc;

  int   n_checks;
  int   n_fail;
  obs_t exp_q[$];

  interrupt_controller #(
    .VECTOR (32'h0000_0100)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .irq               (irq),
    .global_ie         (global_ie),
    .PCE               (PCE),
    .validE            (validE),
    .mretE             (mretE),
    .stopped_interrupt (stopped_interrupt),
    .interrupt_en      (interrupt_en),
    .PCIntSel          (PCIntSel),
    .PCInt             (PCInt),
    .irq_ack           (irq_ack),
    .in_handler        (in_handler),
    .epc               (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.stop  = stopped_interrupt;
    o.ien   = interrupt_en;
    o.sel   = PCIntSel;
    o.ack   = irq_ack;
    o.inh   = in_handler;
    o.pcint = PCInt;
    o.epc   = epc;
    return o;
  endfunction

  function automatic obs_t mk(logic stop, logic ien, logic sel, logic ack, logic inh,
                              logic [31:0] pcint, logic [31:0] e);
    obs_t o;
    o.stop  = stop;
    o.ien   = ien;
    o.sel   = sel;
    o.ack   = ack;
    o.inh   = inh;
    o.pcint = pcint;
    o.epc   = e;
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic chk_obs(string name, obs_t act, obs_t exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got stop=%b ien=%b sel=%b ack=%b inh=%b pcint=%h epc=%h, expected stop=%b ien=%b sel=%b ack=%b inh=%b pcint=%h epc=%h (t=%0t)",
               name, act.stop, act.ien, act.sel, act.ack, act.inh, act.pcint, act.epc,
               exp_v.stop, exp_v.ien, exp_v.sel, exp_v.ack, exp_v.inh, exp_v.pcint, exp_v.epc, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on the falling edge, any visible event must match the next expectation.
  always @(negedge clk) begin
    obs_t act;
    if (!reset) begin
      act = sample();
      if (act.stop || act.ien || act.sel || act.ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got stop=%b ien=%b sel=%b ack=%b pcint=%h, expected no event (t=%0t)",
                   act.stop, act.ien, act.sel, act.ack, act.pcint, $time);
        end else begin
          chk_obs("event", act, exp_q.pop_front());
        end
      end
    end
  end

  localparam logic [31:0] VEC = 32'h0000_0100;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    irq       = 1'b0;
    global_ie = 1'b1;
    PCE       = 32'h0000_0040;
    validE    = 1'b1;
    mretE     = 1'b0;
    #3;
    chk_obs("reset_state", sample(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Basic take: irq rises before edge N; kill visible after edge N+1.
    irq = 1'b1;
    tick();
    tick();
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    tick();
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, VEC, 32'h0000_0040));
    tick();
    chk("in_handler_after_take", {31'h0, in_handler}, 32'h1);
    chk("epc_after_take", epc, 32'h0000_0040);

    // No nesting: irq toggling inside the handler produces nothing.
    for (int i = 0; i < 6; i++) begin
      irq = ~irq;
      tick();
    end
    irq = 1'b0;
    tick();
    tick();
    tick();
    // mret on a bubble does not return.
    mretE  = 1'b1;
    validE = 1'b0;
    tick();
    chk("in_handler_bubble_mret", {31'h0, in_handler}, 32'h1);
    validE = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040));
    tick();
    mretE = 1'b0;
    chk("in_handler_after_return", {31'h0, in_handler}, 32'h0);

    // Bubble wait: irq_s high but validE=0 for 3 cycles, take on first valid cycle.
    validE = 1'b0;
    PCE    = 32'h0000_0070;
    irq    = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("no_take_on_bubble", {31'h0, in_handler}, 32'h0);
    validE = 1'b1;
    PCE    = 32'h0000_0088;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0040));
    tick();
    // Vector cycle: mret here is ignored, PCE changes must not touch epc.
    PCE   = 32'h0000_0090;
    mretE = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, VEC, 32'h0000_0088));
    tick();
    mretE = 1'b0;
    chk("epc_bubble_take", epc, 32'h0000_0088);
    tick();
    // Return while irq still high, then an immediate re-take from IDLE.
    mretE = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0088, 32'h0000_0088));
    tick();
    mretE = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0088));
    tick();
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, VEC, 32'h0000_0090));
    tick();
    chk("in_handler_retake", {31'h0, in_handler}, 32'h1);

    // Reset in the middle of the handler clears everything immediately.
    irq = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_obs("reset_mid_handler", sample(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    tick();
    reset = 1'b0;
    tick();
    mretE = 1'b1;
    tick();
    tick();
    mretE = 1'b0;
    chk("no_handler_after_reset", {31'h0, in_handler}, 32'h0);

    // Masked: global_ie=0 with irq high for many cycles takes nothing.
    global_ie = 1'b0;
    irq       = 1'b1;
    PCE       = 32'h0000_00A0;
    for (int i = 0; i < 12; i++) tick();
    mretE = 1'b1;
    tick();
    mretE = 1'b0;
    chk("masked_no_take", {31'h0, in_handler}, 32'h0);
    // Unmask: the pending request is taken this cycle.
    global_ie = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    tick();
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, VEC, 32'h0000_00A0));
    tick();
    irq       = 1'b0;
    global_ie = 1'b0;
    tick();
    chk("in_handler_unmasked", {31'h0, in_handler}, 32'h1);
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and reset.
REQ-002 Parameter VECTOR, default 32'h0000_0100, SHALL be the handler entry address.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  async active-high reset.
REQ-005 irq  in  1  external interrupt request, level, asynchronous to clk.
REQ-006 global_ie  in  1  global interrupt enable.
REQ-007 PCE  in  32  PC of the instruction in Execute.
REQ-008 validE  in  1  Execute holds a real (non-bubble) instruction.
REQ-009 mretE  in  1  Execute instruction is a return-from-interrupt.
REQ-010 stopped_interrupt  out  1  kills the Decode, Execute and Memory-entry instructions (hazard unit FlushD/FlushE/FlushM).
REQ-011 interrupt_en  out  1  vector-entry cycle (hazard unit FlushD).
REQ-012 PCIntSel  out  1  PC mux select for PCInt.
REQ-013 PCInt  out  32  redirect target.
REQ-014 irq_ack  out  1  one-cycle acknowledge to the source.
REQ-015 in_handler  out  1  handler executing.
REQ-016 epc  out  32  saved return PC.

Function
REQ-017 irq SHALL pass through a 2-flop synchronizer (irq_s); an irq rising before edge N SHALL make irq_s high after edge N+1.
REQ-018 The FSM SHALL have exactly three states: IDLE, VECTOR, HANDLER.
REQ-019 The take condition SHALL be: in IDLE with irq_s & global_ie & validE & !mretE.
REQ-020 When the take condition holds, stopped_interrupt SHALL be 1 combinationally in that same cycle.
REQ-021 On a take, epc SHALL load PCE at the next edge and the state SHALL go to VECTOR.
REQ-022 In IDLE, while validE=0 or global_ie=0, no take SHALL occur; the request waits and is not lost while irq_s stays high.
REQ-023 VECTOR SHALL last one cycle: interrupt_en=1, PCIntSel=1, PCInt=VECTOR and irq_ack=1; the next state is HANDLER.
REQ-024 In HANDLER: in_handler=1 and irq_s SHALL be ignored (no nesting).
REQ-025 The return condition SHALL be: in HANDLER with mretE & validE.
REQ-026 On the return condition: stopped_interrupt=1, PCIntSel=1 and PCInt=epc in the same cycle, and the next state is IDLE.
REQ-027 mretE in IDLE or VECTOR SHALL be ignored (no redirect, no state change).
REQ-028 After a return, at least one IDLE cycle SHALL elapse before the next take; a still-high irq_s re-takes on the next qualifying cycle.
REQ-029 PCIntSel SHALL have priority over PCSrcE at the PC mux; the PCSrcE of a killed Execute instruction SHALL have no architectural effect.
REQ-030 Outputs not asserted by REQ-020, REQ-023 or REQ-026 SHALL be 0; PCInt SHALL be 0 when PCIntSel=0; epc SHALL hold its value outside a take.

Reset
REQ-031 Reset SHALL immediately force: state=IDLE, synchronizer flops=0, epc=0, and all outputs 0.
REQ-032 Reset asserted in VECTOR or HANDLER SHALL abandon the handler with no return redirect.

Structure
REQ-033 FSM state encodings and the VECTOR default SHALL live in the shared pipeline package.
REQ-034 The synchronizer SHALL be a sub-module named sync_2ff, reused for other asynchronous inputs.
REQ-035 The block SHALL contain no other sub-modules; the FSM, epc register and output decode are local.

Verification
REQ-036 Take: irq rises, global_ie=1, validE=1, PCE=32'h0000_0040 -> stopped_interrupt pulses 2 cycles later; next cycle PCInt=32'h0000_0100, interrupt_en=1, irq_ack=1; epc=32'h0000_0040.
REQ-037 Bubble wait: irq_s high, validE=0 for 3 cycles then 1 with PCE=32'h0000_0088 -> take occurs on the validE=1 cycle only; epc=32'h0000_0088.
REQ-038 Return: in HANDLER, mretE=1, validE=1 -> same cycle stopped_interrupt=1, PCIntSel=1, PCInt=epc; next cycle in_handler=0.
REQ-039 Masking/nesting: global_ie=0 with irq high for 10 cycles -> no take; irq toggling while in HANDLER -> no irq_ack.
REQ-040 Reset mid-handler: reset asserted in HANDLER -> in_handler=0 and PCIntSel=0 immediately; a later mretE produces no redirect.
REQ-041 Simultaneous events: take cycle with PCSrcE=1 and mretE=0 -> the following cycle PCInt=VECTOR regardless of the branch.
